instr_encoder: RTL and testbench

INSTR_ENCODER -- requirements
Module: instr_encoder

---
 rtl/instr_encoder_if.sv | 34 +++
 rtl/instr_encoder.sv | 125 ++++++++++++
 tb/tb_instr_encoder.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/instr_encoder_if.sv
// Field-bundle input, memory-write output and status signals of the instruction encoder.
// master drives bundles and write-ready; slave is the encoder itself.
interface instr_encoder_if #(
    parameter int unsigned MEM_AWIDTH = 8
);
    logic                  e_i_valid;
    logic                  e_o_ready;
    logic [5:0]            e_i_opcode;
    logic [5:0]            e_i_funct;
    logic [4:0]            e_i_addr_rs;
    logic [4:0]            e_i_addr_rt;
    logic [4:0]            e_i_addr_rd;
    logic [15:0]           e_i_imm;
    logic                  e_i_clr;
    logic                  e_o_we;
    logic [MEM_AWIDTH-1:0] e_o_waddr;
    logic [31:0]           e_o_wdata;
    logic                  e_i_wready;
    logic                  e_o_err;
    logic [7:0]            e_o_err_cnt;
    logic                  e_o_wrap;

    modport master (
        output e_i_valid, e_i_opcode, e_i_funct, e_i_addr_rs, e_i_addr_rt, e_i_addr_rd,
               e_i_imm, e_i_clr, e_i_wready,
        input  e_o_ready, e_o_we, e_o_waddr, e_o_wdata, e_o_err, e_o_err_cnt, e_o_wrap
    );

    modport slave (
        input  e_i_valid, e_i_opcode, e_i_funct, e_i_addr_rs, e_i_addr_rt, e_i_addr_rd,
               e_i_imm, e_i_clr, e_i_wready,
        output e_o_ready, e_o_we, e_o_waddr, e_o_wdata, e_o_err, e_o_err_cnt, e_o_wrap
    );
endinterface

// File: rtl/instr_encoder.sv
// Packs MIPS-style field bundles into 32-bit words and streams them to instruction memory
// through a two-entry buffer with an auto-incrementing write address.
module instr_encoder #(
    parameter int unsigned MEM_AWIDTH = 8,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input logic            e_clk,
    input logic            e_rst,
    instr_encoder_if.slave bus
);
    localparam logic [5:0] OpRtype = 6'h00;
    localparam logic [5:0] OpLoad  = 6'h23;
    localparam logic [5:0] OpStore = 6'h2B;
    localparam logic [5:0] OpBeq   = 6'h04;
    localparam logic [5:0] OpBne   = 6'h05;
    localparam logic [5:0] OpAddi  = 6'h08;
    localparam logic [5:0] OpAddiu = 6'h09;
    localparam logic [5:0] OpSlti  = 6'h0A;
    localparam logic [5:0] OpSltiu = 6'h0B;
    localparam logic [5:0] OpAndi  = 6'h0C;
    localparam logic [5:0] OpOri   = 6'h0D;
    localparam logic [5:0] OpXori  = 6'h0E;

    localparam logic [5:0] FnAdd = 6'h20;
    localparam logic [5:0] FnSub = 6'h22;
    localparam logic [5:0] FnAnd = 6'h24;
    localparam logic [5:0] FnOr  = 6'h25;
    localparam logic [5:0] FnXor = 6'h26;

    localparam logic [1:0] CntFull = 2'(FIFO_DEPTH);

    logic [31:0]           mem_q [2];
    logic [31:0]           mem_d [2];
    logic                  wr_ptr_q, wr_ptr_d;
    logic                  rd_ptr_q, rd_ptr_d;
    logic [1:0]            count_q, count_d;
    logic                  ready_q, ready_d;
    logic [MEM_AWIDTH-1:0] waddr_q, waddr_d;
    logic                  err_q, err_d;
    logic [7:0]            err_cnt_q, err_cnt_d;
    logic                  wrap_q, wrap_d;

    logic [31:0] enc_word;
    logic        word_ok;
    logic        accept, push, pop;

    always_comb begin
        word_ok  = 1'b0;
        enc_word = {bus.e_i_opcode, bus.e_i_addr_rs, bus.e_i_addr_rt, bus.e_i_imm};
        case (bus.e_i_opcode)
            OpRtype: begin
                enc_word = {bus.e_i_opcode, bus.e_i_addr_rs, bus.e_i_addr_rt, bus.e_i_addr_rd,
                            5'b0, bus.e_i_funct};
                case (bus.e_i_funct)
                    FnAdd, FnSub, FnAnd, FnOr, FnXor: word_ok = 1'b1;
                    default:                          word_ok = 1'b0;
                endcase
            end
            OpLoad, OpStore, OpBeq, OpBne, OpAddi, OpAddiu, OpSlti, OpSltiu, OpAndi, OpOri,
            OpXori: word_ok = 1'b1;
            default: word_ok = 1'b0;
        endcase
    end

    always_comb begin
        accept = bus.e_i_valid && ready_q;
        // Unsupported bundles are still consumed, only never buffered.
        push   = accept && word_ok;
        pop    = (count_q != 2'd0) && bus.e_i_wready;

        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q ^ push;
        rd_ptr_d = rd_ptr_q ^ pop;
        if (push) begin
            mem_d[wr_ptr_q] = enc_word;
        end
        count_d = count_q + {1'b0, push} - {1'b0, pop};
        ready_d = (count_d != CntFull);

        err_d     = accept && !word_ok;
        err_cnt_d = (err_d && (err_cnt_q != 8'hFF)) ? err_cnt_q + 8'd1 : err_cnt_q;

        // Clear wins over a same-cycle increment and suppresses the wrap pulse.
        wrap_d  = pop && !bus.e_i_clr && (&waddr_q);
        waddr_d = waddr_q;
        if (bus.e_i_clr) begin
            waddr_d = '0;
        end else if (pop) begin
            waddr_d = waddr_q + 1'b1;
        end
    end

    always_ff @(posedge e_clk) begin
        if (!e_rst) begin
            mem_q[0]  <= '0;
            mem_q[1]  <= '0;
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            count_q   <= 2'd0;
            ready_q   <= 1'b0;
            waddr_q   <= '0;
            err_q     <= 1'b0;
            err_cnt_q <= 8'd0;
            wrap_q    <= 1'b0;
        end else begin
            mem_q     <= mem_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            ready_q   <= ready_d;
            waddr_q   <= waddr_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
            wrap_q    <= wrap_d;
        end
    end

    assign bus.e_o_ready   = ready_q;
    assign bus.e_o_we      = (count_q != 2'd0);
    assign bus.e_o_wdata   = mem_q[rd_ptr_q];
    assign bus.e_o_waddr   = waddr_q;
    assign bus.e_o_err     = err_q;
    assign bus.e_o_err_cnt = err_cnt_q;
    assign bus.e_o_wrap    = wrap_q;
endmodule

// File: tb/tb_instr_encoder.sv
// Randomised scoreboard bench for instr_encoder: a reference model predicts words, addresses,
// error and wrap pulses; a negedge monitor compares them against the DUT every cycle.
module tb_instr_encoder;
    localparam int unsigned AW = 2;

    logic e_clk = 1'b0;
    logic e_rst = 1'b0;

    instr_encoder_if #(.MEM_AWIDTH(AW)) bus ();

    instr_encoder #(.MEM_AWIDTH(AW), .FIFO_DEPTH(2)) dut (
        .e_clk(e_clk),
        .e_rst(e_rst),
        .bus  (bus)
    );

    always #5 e_clk = ~e_clk;

    int checks = 0;
    int errors = 0;

    logic [5:0] sup_ops [12] = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h08,
                                 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E};
    logic [5:0] sup_fns [5]  = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26};

    function automatic bit supported(logic [5:0] op, logic [5:0] fn);
        bit ok = 0;
        foreach (sup_ops[i]) if (sup_ops[i] == op) ok = 1;
        if (op == 6'h00) begin
            ok = 0;
            foreach (sup_fns[i]) if (sup_fns[i] == fn) ok = 1;
        end
        return ok;
    endfunction

    function automatic logic [31:0] ref_word(logic [5:0] op, logic [4:0] rs, logic [4:0] rt,
                                             logic [4:0] rd, logic [5:0] fn, logic [15:0] imm);
        logic [31:0] w;
        w = (32'(op) << 26) | (32'(rs) << 21) | (32'(rt) << 16);
        if (op == 6'h00) w = w | (32'(rd) << 11) | 32'(fn);
        else             w = w | 32'(imm);
        return w;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model state, advanced once per rising edge.
    logic [31:0]   exp_q [$];
    logic [AW-1:0] m_addr   = '0;
    int            m_cnt    = 0;
    bit            m_err    = 0;
    bit            m_wrap   = 0;
    bit            m_ready  = 0;
    bit            m_in_rst = 0;
    bit            started  = 0;

    initial forever begin
        @(posedge e_clk);
        started = 1;
        if (!e_rst) begin
            exp_q.delete();
            m_addr = '0; m_cnt = 0; m_err = 0; m_wrap = 0; m_ready = 0; m_in_rst = 1;
        end else begin
            bit acc, pop;
            m_in_rst = 0;
            acc      = bus.e_i_valid && m_ready;
            pop      = (exp_q.size() > 0) && bus.e_i_wready;
            m_err    = 0;
            m_wrap   = 0;
            if (pop) begin
                void'(exp_q.pop_front());
                m_wrap = !bus.e_i_clr && (int'(m_addr) == (1 << AW) - 1);
            end
            if (bus.e_i_clr) m_addr = '0;
            else if (pop)    m_addr = AW'((int'(m_addr) + 1) % (1 << AW));
            if (acc) begin
                if (supported(bus.e_i_opcode, bus.e_i_funct))
                    exp_q.push_back(ref_word(bus.e_i_opcode, bus.e_i_addr_rs, bus.e_i_addr_rt,
                                             bus.e_i_addr_rd, bus.e_i_funct, bus.e_i_imm));
                else begin
                    m_err = 1;
                    if (m_cnt < 255) m_cnt++;
                end
            end
            m_ready = exp_q.size() < 2;
        end
    end

    // Monitor: compares every DUT output away from the active edge.
    initial forever begin
        @(negedge e_clk);
        if (started) begin
            chk("ready", 32'(bus.e_o_ready), 32'(m_ready));
            chk("we", 32'(bus.e_o_we), 32'(exp_q.size() > 0));
            chk("waddr", 32'(bus.e_o_waddr), 32'(m_addr));
            chk("err", 32'(bus.e_o_err), 32'(m_err));
            chk("err_cnt", 32'(bus.e_o_err_cnt), 32'(m_cnt));
            chk("wrap", 32'(bus.e_o_wrap), 32'(m_wrap));
            if (exp_q.size() > 0) chk("wdata", bus.e_o_wdata, exp_q[0]);
            else if (m_in_rst)    chk("wdata_rst", bus.e_o_wdata, 32'h0);
        end
    end

    bit rand_mode = 0;

    initial forever begin
        @(posedge e_clk);
        #1;
        if (rand_mode) begin
            bus.e_i_wready = ($urandom_range(0, 3) != 0);
            bus.e_i_clr    = ($urandom_range(0, 30) == 0);
        end
    end

    task automatic send(logic [5:0] op, logic [4:0] rs, logic [4:0] rt, logic [4:0] rd,
                        logic [5:0] fn, logic [15:0] imm);
        int n = 0;
        bus.e_i_opcode  = op;
        bus.e_i_addr_rs = rs;
        bus.e_i_addr_rt = rt;
        bus.e_i_addr_rd = rd;
        bus.e_i_funct   = fn;
        bus.e_i_imm     = imm;
        bus.e_i_valid   = 1'b1;
        forever begin
            @(negedge e_clk);
            if (bus.e_o_ready) break;
            if (++n > 100) begin
                checks++;
                errors++;
                $display("FAIL accept_timeout: got ready=0 expected ready=1 at %0t", $time);
                break;
            end
        end
        @(posedge e_clk);
        #1;
        bus.e_i_valid = 1'b0;
    endtask

    task automatic idle(int n);
        repeat (n) @(posedge e_clk);
        #1;
    endtask

    task automatic send_random();
        logic [5:0] op, fn;
        op = 6'($urandom);
        fn = 6'($urandom);
        if ($urandom_range(0, 9) < 7) begin
            op = sup_ops[$urandom_range(0, 11)];
            if (op == 6'h00) fn = sup_fns[$urandom_range(0, 4)];
        end
        send(op, 5'($urandom), 5'($urandom), 5'($urandom), fn, 16'($urandom));
    endtask

    initial begin
        bus.e_i_valid = 0; bus.e_i_opcode = 0; bus.e_i_funct = 0;
        bus.e_i_addr_rs = 0; bus.e_i_addr_rt = 0; bus.e_i_addr_rd = 0;
        bus.e_i_imm = 0; bus.e_i_clr = 0; bus.e_i_wready = 0;
        e_rst = 0;
        repeat (2) @(posedge e_clk);
        #1 e_rst = 1;
        idle(2);

        // ADD then LOAD with junk rd/funct
        bus.e_i_wready = 1;
        send(6'h00, 5'd1, 5'd2, 5'd3, 6'h20, 16'hBEEF);
        send(6'h23, 5'd4, 5'd5, 5'd31, 6'h3F, 16'h0010);
        idle(3);

        // Backpressure: third bundle waits until the memory drains
        bus.e_i_wready = 0;
        fork
            begin
                send(6'h08, 5'd6, 5'd7, 5'd0, 6'h00, 16'h1234);
                send(6'h00, 5'd8, 5'd9, 5'd10, 6'h22, 16'h0);
                send(6'h0D, 5'd11, 5'd12, 5'd0, 6'h00, 16'hFFFF);
            end
            begin
                idle(8);
                bus.e_i_wready = 1;
            end
        join
        idle(4);

        // Errors and saturation
        send(6'h3F, 5'd1, 5'd1, 5'd1, 6'h00, 16'h0);
        send(6'h00, 5'd1, 5'd1, 5'd1, 6'h08, 16'h0);
        for (int i = 0; i < 256; i++) begin
            logic [5:0] op, fn;
            do begin
                op = 6'($urandom);
                fn = 6'($urandom);
            end while (supported(op, fn));
            send(op, 5'($urandom), 5'($urandom), 5'($urandom), fn, 16'($urandom));
        end
        idle(2);

        // Wrap through all four addresses, then clear mid-stream
        for (int i = 0; i < 5; i++) send(6'h09, 5'(i), 5'(i + 1), 5'd0, 6'd0, 16'(i * 3));
        idle(3);
        bus.e_i_clr = 1;
        idle(1);
        bus.e_i_clr = 0;
        send(6'h0E, 5'd3, 5'd3, 5'd0, 6'd0, 16'hA5A5);
        idle(3);

        // Random traffic with random backpressure/clear and one reset mid-operation
        rand_mode = 1;
        for (int i = 0; i < 300; i++) begin
            send_random();
            if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 3));
            if (i == 150) begin
                e_rst = 0;
                idle(2);
                e_rst = 1;
            end
        end
        rand_mode = 0;
        idle(1);
        bus.e_i_wready = 1;
        bus.e_i_clr    = 0;
        idle(6);
        @(negedge e_clk);
        chk("drain_we", 32'(bus.e_o_we), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
